// File: rtl/rr_arb_pkg.sv
// Shared constants and helpers for the round-robin stream arbiter family.
// RR_ARB_GRANT_CNT_EN (defined in the top) enables per-requester grant counters.
package rr_arb_pkg;

   localparam int DEF_N_REQ  = 4;
   localparam int DEF_DATA_W = 8;

   localparam int             CNT_W   = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Index width for n requesters; never narrower than one bit.
   function automatic int calc_id_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate so the slot after last_grant is bit 0,
// priority-encode the lowest set bit, then rotate the index back.
module rr_pick
   import rr_arb_pkg::*;
#(
   parameter int N    = DEF_N_REQ,
   parameter int ID_W = calc_id_w(N)
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] last_grant,
   output logic [ID_W-1:0] gnt_idx,
   output logic            gnt_any
);

   logic [ID_W-1:0] start;
   logic [N-1:0]    rot;
   logic [ID_W-1:0] pos;
   logic [ID_W:0]   sum;

   always_comb begin
      start = (last_grant == ID_W'(N - 1)) ? '0 : last_grant + 1'b1;
      // Doubling the vector turns the rotate into a plain shift.
      rot   = N'({req, req} >> start);
      pos   = '0;
      for (int j = N - 1; j >= 0; j--) begin
         if (rot[j]) begin
            pos = ID_W'(j);
         end
      end
      sum = {1'b0, start} + {1'b0, pos};
      if (sum >= (ID_W + 1)'(N)) begin
         sum = sum - (ID_W + 1)'(N);
      end
      gnt_idx = sum[ID_W-1:0];
      gnt_any = |req;
   end

endmodule

// File: rtl/rr_stream_arbiter.sv
// Round-robin arbiter feeding one registered valid/ready output stage.
// Define RR_ARB_GRANT_CNT_EN to add saturating per-requester grant counters.
module rr_stream_arbiter
   import rr_arb_pkg::*;
#(
   parameter int N_REQ  = DEF_N_REQ,
   parameter int DATA_W = DEF_DATA_W,
   parameter int ID_W   = calc_id_w(N_REQ)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_REQ-1:0]          req_valid,
   output logic [N_REQ-1:0]          req_ready,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
`ifdef RR_ARB_GRANT_CNT_EN
   input  logic                      clr_cnt,
   output logic [N_REQ*CNT_W-1:0]    grant_cnt,
`endif
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_W-1:0]         out_data,
   output logic [ID_W-1:0]           out_id
);

   logic              load;
   logic              take;
   logic [ID_W-1:0]   last_grant;
   logic [ID_W-1:0]   gnt_idx;
   logic              gnt_any;
   logic [DATA_W-1:0] sel_data;

   assign load = !out_valid || out_ready;
   assign take = load && gnt_any;

   rr_pick #(
      .N    (N_REQ),
      .ID_W (ID_W)
   ) u_pick (
      .req        (req_valid),
      .last_grant (last_grant),
      .gnt_idx    (gnt_idx),
      .gnt_any    (gnt_any)
   );

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
         assign req_ready[gi] = take && (gnt_idx == ID_W'(gi));
      end
   endgenerate

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt_idx == ID_W'(i)) begin
            sel_data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Priority only rotates on an accepted transfer, so stalls never skip anyone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_id     <= '0;
         last_grant <= ID_W'(N_REQ - 1);
      end else if (load) begin
         if (gnt_any) begin
            out_valid  <= 1'b1;
            out_data   <= sel_data;
            out_id     <= gnt_idx;
            last_grant <= gnt_idx;
         end else begin
            out_valid  <= 1'b0;
         end
      end
   end

`ifdef RR_ARB_GRANT_CNT_EN
   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cnt
         logic [CNT_W-1:0] cnt_reg;

         // Clear wins over a same-cycle grant.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt_reg <= '0;
            end else if (clr_cnt) begin
               cnt_reg <= '0;
            end else if (req_ready[gi] && (cnt_reg != CNT_MAX)) begin
               cnt_reg <= cnt_reg + 1'b1;
            end
         end

         assign grant_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
      end
   endgenerate
`endif

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Directed bench for rr_stream_arbiter: a round-robin reference model pushes expected
// beats into a queue on each modelled grant; the output register is checked against it.
module tb_rr_stream_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int CW = 16;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*DW-1:0] req_data;
   logic            out_valid;
   logic            out_ready;
   logic [DW-1:0]   out_data;
   logic [1:0]      out_id;
`ifdef RR_ARB_GRANT_CNT_EN
   logic            clr_cnt;
   logic [N*CW-1:0] grant_cnt;
`endif

   rr_stream_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
`ifdef RR_ARB_GRANT_CNT_EN
      .clr_cnt   (clr_cnt),
      .grant_cnt (grant_cnt),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_id    (out_id)
   );

   always #5 clk = ~clk;

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [9:0]  sb_q[$];
   int          m_last;
   int          m_cnt[N];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      sb_q.delete();
      m_last = N - 1;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
   endtask

   task automatic set_data(input int i, input logic [DW-1:0] v);
      req_data[i*DW +: DW] = v;
   endtask

   // One clock: check at the falling edge, advance the model, return 1 time unit after the rising edge.
   task automatic tick();
      logic [N-1:0] exp_rdy;
      int           g;
      bit           found;
      bit           load;
      @(negedge clk);
      found = 0;
      g     = 0;
      for (int k = 1; k <= N; k++) begin
         int i;
         i = (m_last + k) % N;
         if (!found && req_valid[i]) begin
            found = 1;
            g     = i;
         end
      end
      load    = (sb_q.size() == 0) || out_ready;
      exp_rdy = (load && found) ? (N'(1) << g) : '0;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
      if (sb_q.size() != 0) chk("out_beat", 32'({out_id, out_data}), 32'(sb_q[0]));
`ifdef RR_ARB_GRANT_CNT_EN
      for (int i = 0; i < N; i++) chk("grant_cnt", 32'(grant_cnt[i*CW +: CW]), 32'(m_cnt[i]));
`endif
      if (sb_q.size() != 0 && out_ready) void'(sb_q.pop_front());
      if (load && found) begin
         sb_q.push_back({2'(g), req_data[g*DW +: DW]});
         m_last = g;
      end
`ifdef RR_ARB_GRANT_CNT_EN
      for (int i = 0; i < N; i++) begin
         if (clr_cnt) m_cnt[i] = 0;
         else if (load && found && g == i && m_cnt[i] < 65535) m_cnt[i]++;
      end
`endif
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      out_ready = 1'b0;
`ifdef RR_ARB_GRANT_CNT_EN
      clr_cnt   = 1'b0;
`endif
      model_reset();

      // Reset state
      tick();
      chk("rst_out_data", 32'(out_data), 32'h0);
      chk("rst_out_id", 32'(out_id), 32'h0);
      tick();
      rst_n = 1'b1;
      tick();

      // Single requester, first beat
      req_valid = 4'b0001;
      set_data(0, 8'hA5);
      out_ready = 1'b1;
      tick();
      req_valid = '0;
      chk("first_data", 32'(out_data), 32'hA5);
      chk("first_id", 32'(out_id), 32'h0);
      tick();

      // All requesters streaming
      for (int i = 0; i < N; i++) set_data(i, 8'h10 + 8'(i));
      req_valid = 4'b1111;
      for (int c = 0; c < 9; c++) tick();

      // Backpressure holding 3C
      req_valid = 4'b0100;
      set_data(2, 8'h3C);
      tick();
      out_ready = 1'b0;
      req_valid = 4'b1011;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("bp_hold_data", 32'(out_data), 32'h3C);
         chk("bp_hold_id", 32'(out_id), 32'h2);
      end
      out_ready = 1'b1;
      tick();
      chk("bp_release_id", 32'(out_id), 32'h3);
      chk("bp_release_data", 32'(out_data), 32'h13);

      // Wrap from last_grant=1 with requesters 0 and 1
      req_valid = 4'b0010;
      tick();
      req_valid = 4'b0011;
      tick();
      chk("wrap_first_id", 32'(out_id), 32'h0);
      tick();
      chk("wrap_second_id", 32'(out_id), 32'h1);
      req_valid = '0;
      tick();

      // Asynchronous reset mid-stream
      req_valid = 4'b1111;
      tick();
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'h0);
      chk("async_rst_data", 32'(out_data), 32'h0);
      model_reset();
      req_valid = '0;
      tick();
      rst_n = 1'b1;
      req_valid = 4'b1111;
      tick();
      chk("post_rst_id", 32'(out_id), 32'h0);

      // Random traffic
      for (int c = 0; c < 300; c++) begin
         req_valid = 4'($urandom_range(0, 15));
         out_ready = 1'($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) set_data(i, 8'($urandom));
         tick();
      end

`ifdef RR_ARB_GRANT_CNT_EN
      out_ready = 1'b1;
      clr_cnt   = 1'b1;
      req_valid = '0;
      tick();
      clr_cnt   = 1'b0;
      req_valid = 4'b0100;
      for (int c = 0; c < 5; c++) tick();
      req_valid = '0;
      tick();
      chk("cnt2_five", 32'(grant_cnt[2*CW +: CW]), 32'd5);
      req_valid = 4'b0100;
      clr_cnt   = 1'b1;
      tick();
      clr_cnt   = 1'b0;
      req_valid = '0;
      chk("cnt2_clr", 32'(grant_cnt[2*CW +: CW]), 32'd0);
      req_valid = 4'b1000;
      for (int c = 0; c < 65540; c++) tick();
      chk("cnt3_sat", 32'(grant_cnt[3*CW +: CW]), 32'hFFFF);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/rr_stream_arbiter.md
Name: rr_stream_arbiter

Overview:
- Shares one registered valid/ready output stage between N_REQ single-beat requesters using round-robin arbitration.
- Sits in front of the downstream consumer, in the position of a single-stage pipeline register.
- Selects one requester per cycle, captures its data and source ID into an output register, and applies backpressure to all others.
- Latency 1 cycle; sustained throughput 1 beat/cycle when out_ready is held high.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- DATA_W, 8, data width per requester.
- ID_W, $clog2(N_REQ), width of out_id (derived; do not override).

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  N_REQ  per-requester valid.
- req_ready  output  N_REQ  per-requester ready; at most one bit high.
- req_data  input  N_REQ*DATA_W  packed data; requester i occupies bits [i*DATA_W +: DATA_W].
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_W  registered data.
- out_id  output  ID_W  index of the requester that supplied out_data.

Behaviour:
- Reset (asynchronous, rst_n=0): out_valid=0, out_data=0, out_id=0, last_grant=N_REQ-1. req_ready is combinational and therefore 0 while out_valid=0 and no req_valid is asserted.
- load = !out_valid || out_ready. The stage can accept a new beat this cycle.
- Grant is combinational. Search starts at index (last_grant+1) mod N_REQ, wraps, and stops at the first i with req_valid[i]=1. Result: gnt_idx, gnt_any.
- req_ready[i] = load && gnt_any && (i == gnt_idx). All other ready bits are 0.
- Capture on the clock edge when load && gnt_any: out_data <= req_data[gnt_idx], out_id <= gnt_idx, out_valid <= 1, last_grant <= gnt_idx.
- When load && !gnt_any: out_valid <= 0 (drains); out_data and out_id hold.
- When !load (out_valid=1, out_ready=0): all registers hold and all req_ready are 0.
- last_grant updates only on an accepted input transfer. A stalled cycle never rotates priority.
- Simultaneous drain and fill (out_valid=1, out_ready=1, a request present) accepts the new beat in the same cycle, giving no bubble.
- Fairness: a requester holding valid is granted within N_REQ accepted transfers.
- Wrap-around: after last_grant=N_REQ-1, index 0 has highest priority.
- Only one requester valid: it is granted every load cycle regardless of last_grant.
- Reset asserted mid-operation: the held beat is discarded and out_valid drops immediately (asynchronously).
- Requesters must hold valid and data stable until ready. The arbiter does not check this.
- Requirement: no combinational path from out_ready to out_valid/out_data. A path from out_ready to req_ready is permitted.

Optional Feature:
- Macro: RR_ARB_GRANT_CNT_EN.
- Defined:
  - Adds output port grant_cnt, N_REQ*16 bits, packed per requester.
  - Each 16-bit counter increments on its requester's accepted transfer and saturates at 16'hFFFF.
  - Counters reset to 0.
  - Adds input clr_cnt (1 bit). A synchronous clear to 0 that takes priority over a same-cycle increment.
- Undefined:
  - Neither port exists and no counter logic is generated.
  - All other behaviour is identical.

Decomposition:
- Package rr_arb_pkg:
  - Default N_REQ and DATA_W localparams.
  - CNT_W=16 and CNT_MAX.
  - Function calc_id_w(n).
- Sub-module rr_pick (purely combinational):
  - Inputs: req vector, last_grant.
  - Outputs: gnt_idx, gnt_any.
  - Implement as a rotate / priority-encode / rotate-back. Reusable by other arbiters.
- The top level owns the output register, last_grant and the optional counters.

Test Plan:
- Reset, then req_valid=4'b0001, req_data[0]=8'hA5, out_ready=1 -> req_ready=4'b0001 in cycle 0; next cycle out_valid=1, out_data=A5, out_id=0.
- All four valid continuously with data 8'h10/11/12/13, out_ready=1 -> out_id sequence 0,1,2,3,0,…; out_data matches; no bubbles.
- Backpressure: out_valid=1 holding 8'h3C, out_ready=0 for 3 cycles -> out_data stable at 3C, req_ready=0, last_grant unchanged; on out_ready=1, next requester is captured the same cycle.
- last_grant=1, req_valid=4'b0011 -> requester 0 is granted (wrap), then 1 is granted.
- Assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0 without waiting for a clock edge; after release, requester 0 has priority.
- With RR_ARB_GRANT_CNT_EN: 5 grants to requester 2 -> grant_cnt[2]=5; clr_cnt pulsed together with a grant -> 0. Preload near saturation via a long run and confirm the counter holds at FFFF.
